// File: rtl/u_32b_seq_mult.sv
// u_32b_seq_mult: iterative 32x32 unsigned shift-and-add multiplier.
// Wraps an external combinational 32-bit ripple-carry adder. The block drives
// the adder operands from its own registers, and in RUN it folds
// {carry, sum} back into the upper half of the accumulator while the
// multiplier bits shift out of the lower half LSB-first. After 32 iterations
// the register pair {acc_hi, acc_lo} holds the exact 64-bit product.
// WIDTH is fixed at 32 to match the adder stage. Other values are not
// supported.

module u_32b_seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  input  logic [31:0] add_sum,
  input  logic [31:0] add_cout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [5:0] LAST_ITER = 6'd31;

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [31:0] mcand_r;
  logic [31:0] acc_hi_r;
  logic [31:0] acc_lo_r;
  logic [5:0]  cnt_r;
  logic        in_ready_r;
  logic        out_valid_r;
  logic [31:0] add_b_s;

  // Only the top carry of the chain is needed. The lower carries are folded
  // into a sink so the adder interface can stay the full width.
  logic        unused_cout_s;
  assign unused_cout_s = ^add_cout[30:0];

  // Next-state decode. A new operand load happens only from IDLE, so requests
  // seen in RUN or DONE are ignored.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_ITER) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register. The handshake flags are registered from the next state,
  // so they always match the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
    end
  end

  // Datapath. Load operands in IDLE and take one partial product per RUN
  // cycle. Hold the result untouched in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_r  <= 32'd0;
      acc_hi_r <= 32'd0;
      acc_lo_r <= 32'd0;
      cnt_r    <= 6'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            mcand_r  <= a;
            acc_hi_r <= 32'd0;
            acc_lo_r <= b;
            cnt_r    <= 6'd0;
          end else begin
            mcand_r  <= mcand_r;
            acc_hi_r <= acc_hi_r;
            acc_lo_r <= acc_lo_r;
            cnt_r    <= cnt_r;
          end
        end
        RUN: begin
          // The 33-bit {carry, sum} shifts right by one into the accumulator
          // pair. The consumed multiplier bit falls off the bottom.
          {acc_hi_r, acc_lo_r} <= {add_cout[31], add_sum, acc_lo_r[31:1]};
          if (cnt_r == LAST_ITER) begin
            cnt_r <= cnt_r;
          end else begin
            cnt_r <= cnt_r + 6'd1;
          end
        end
        DONE: begin
          mcand_r  <= mcand_r;
          acc_hi_r <= acc_hi_r;
          acc_lo_r <= acc_lo_r;
          cnt_r    <= cnt_r;
        end
        default: begin
          mcand_r  <= 32'd0;
          acc_hi_r <= 32'd0;
          acc_lo_r <= 32'd0;
          cnt_r    <= 6'd0;
        end
      endcase
    end
  end

  // Adder operand 2 selection. Add the multiplicand only when the current
  // multiplier bit is set. It is driven in every state, but the adder result
  // is used only in RUN.
  always_comb begin
    add_b_s = 32'd0;
    if (acc_lo_r[0]) begin
      add_b_s = mcand_r;
    end else begin
      add_b_s = 32'd0;
    end
  end

  assign add_a     = acc_hi_r;
  assign add_b     = add_b_s;
  assign add_cin   = 1'b0;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign product   = {acc_hi_r, acc_lo_r};

endmodule

// File: tb/tb_u_32b_seq_mult.sv
// Testbench for u_32b_seq_mult. It models the external ripple-carry adder
// and checks the products against plain 64-bit multiplication.

module tb_u_32b_seq_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic [31:0] add_cout;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  u_32b_seq_mult dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  always #5 clk = ~clk;

  // Rising-edge counter, read at falling edges.
  always @(posedge clk) cyc <= cyc + 1;

  // External adder: a bitwise ripple-carry chain.
  always_comb begin
    logic c;
    c        = add_cin;
    add_sum  = 32'd0;
    add_cout = 32'd0;
    for (int i = 0; i < 32; i++) begin
      add_sum[i]  = add_a[i] ^ add_b[i] ^ c;
      add_cout[i] = (add_a[i] & add_b[i]) | (c & (add_a[i] ^ add_b[i]));
      c           = add_cout[i];
    end
  end

  // One full operation with a latency and result check.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input string name);
    logic [63:0] exp;
    int start;
    int guard;
    exp = 64'(ta) * 64'(tb_);
    @(negedge clk);
    a = ta; b = tb_; in_valid = 1'b1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL %s in_ready: got %b want 1", name, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    start = cyc;
    guard = 0;
    while (out_valid !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (cyc - start + 1 != 33) begin
      fails++; $display("FAIL %s latency: got %0d want 33", name, cyc - start + 1);
    end
    tests++;
    if (product !== exp) begin
      fails++; $display("FAIL %s product: got %h want %h", name, product, exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL %s release: got ov=%b ir=%b want ov=0 ir=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 32'd0; b = 32'd0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 64'd0) begin
      fails++; $display("FAIL reset outputs: got ir=%b ov=%b p=%h want ir=1 ov=0 p=0", in_ready, out_valid, product);
    end
    tests++;
    if (add_a !== 32'd0 || add_b !== 32'd0 || add_cin !== 1'b0) begin
      fails++; $display("FAIL reset adder ports: got a=%h b=%h cin=%b want 0", add_a, add_b, add_cin);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed;
    run_op(32'd3, 32'd5, "3x5");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max_x_max");
    run_op(32'h8000_0000, 32'd2, "msb_x_2");
    run_op(32'd0, 32'h1234, "zero_x");
    run_op(32'h1234, 32'd0, "x_zero");
  endtask

  task automatic test_backpressure;
    logic [63:0] exp;
    int guard;
    exp = 64'(32'hDEAD_BEEF) * 64'(32'h1357_9BDF);
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'h1357_9BDF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (out_valid !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom; in_valid = i[0];
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== exp) begin
        fails++;
        $display("FAIL backpressure cycle %0d: got ov=%b ir=%b p=%h want ov=1 ir=0 p=%h", i, out_valid, in_ready, product, exp);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL backpressure release: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
    run_op(32'd11, 32'd13, "after_backpressure");
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    a = 32'h0BAD_F00D; b = 32'h7777_7777; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 64'd0) begin
      fails++; $display("FAIL reset_mid_run: got ov=%b ir=%b p=%h want ov=0 ir=1 p=0", out_valid, in_ready, product);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(32'd7, 32'd6, "7x6_after_reset");
  endtask

  task automatic test_back_to_back;
    logic [31:0] x1, y1, x2, y2;
    logic [63:0] e1, e2;
    int t1, t2, guard;
    x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom;
    e1 = 64'(x1) * 64'(y1);
    e2 = 64'(x2) * 64'(y2);
    @(negedge clk);
    a = x1; b = y1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    a = x2; b = y2;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL b2b busy in_ready: got %b want 0", in_ready);
    end
    guard = 0;
    while (out_valid !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    t1 = cyc;
    tests++;
    if (product !== e1) begin
      fails++; $display("FAIL b2b first product: got %h want %h", product, e1);
    end
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL b2b idle gap: got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (out_valid !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    t2 = cyc;
    tests++;
    if (t2 - t1 != 34) begin
      fails++; $display("FAIL b2b spacing: got %0d want 34", t2 - t1);
    end
    tests++;
    if (product !== e2) begin
      fails++; $display("FAIL b2b second product: got %h want %h", product, e2);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_random;
    for (int i = 0; i < 1000; i++) begin
      run_op($urandom, $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
